// File: rtl/fxp_alu_sequencer_if.sv
// rtl/fxp_alu_sequencer_if.sv - request/response bus of the fixed-point ALU sequencer
interface fxp_alu_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             busy;

  // Requester side: issues operations and consumes results
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, ovf, busy
  );

  // Sequencer side
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, ovf, busy
  );
endinterface

// File: rtl/fxp_alu_sequencer.sv
// rtl/fxp_alu_sequencer.sv - multi-cycle fixed-point ADD/SUB/MOV/MUL sequencer with rounding and saturation
module fxp_alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fxp_alu_sequencer_if.slave   bus
);

  localparam int AW = 2 * WIDTH;        // shared adder / accumulator width
  localparam int MW = AW - FRAC;        // rounded product magnitude width
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [AW-1:0]    RND      = AW'(1) << (FRAC - 1);
  localparam logic [MW-1:0]    MAG_POS  = MW'((1 << (WIDTH - 1)) - 1);
  localparam logic [MW-1:0]    MAG_NEG  = MW'(1 << (WIDTH - 1));
  localparam logic [WIDTH-1:0] SAT_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MOV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_FIN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           r_state;
  state_e           w_next;
  op_e              r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [AW-1:0]    r_mag_a;
  logic [WIDTH-1:0] r_mag_b;
  logic             r_sign;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;
  logic             w_accept;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [AW-1:0]    w_add_x;
  logic [AW-1:0]    w_add_y;
  logic             w_add_cin;
  logic [AW-1:0]    w_sum;
  logic [MW-1:0]    w_mag;
  logic [WIDTH-1:0] w_exec_res;
  logic             w_exec_ovf;
  logic [WIDTH-1:0] w_fin_res;
  logic             w_fin_ovf;

  assign w_accept = bus.in_valid & w_in_ready;

  // Magnitudes of the incoming operands; |most negative| still fits unsigned
  assign w_abs_a = bus.a[WIDTH-1] ? (~bus.a + ONE_W) : bus.a;
  assign w_abs_b = bus.b[WIDTH-1] ? (~bus.b + ONE_W) : bus.b;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy     = 1'b0;
        w_in_ready = rst_n;
        if (bus.in_valid && rst_n)
          w_next = (bus.op == OP_MUL) ? S_MUL : S_EXEC;
      end
      S_EXEC: w_next = S_DONE;
      S_MUL:  if (r_cnt == LAST_CNT) w_next = S_FIN;
      S_FIN:  w_next = S_DONE;
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand select for the single adder shared by EXEC, MUL steps and FIN rounding
  always_comb begin
    w_add_x   = '0;
    w_add_y   = '0;
    w_add_cin = 1'b0;
    case (r_state)
      S_EXEC: begin
        w_add_x = {{(AW-WIDTH){r_a[WIDTH-1]}}, r_a};
        case (r_op)
          OP_ADD: w_add_y = {{(AW-WIDTH){r_b[WIDTH-1]}}, r_b};
          OP_SUB: begin
            w_add_y   = ~{{(AW-WIDTH){r_b[WIDTH-1]}}, r_b};
            w_add_cin = 1'b1;
          end
          default: w_add_y = '0;
        endcase
      end
      S_MUL: begin
        w_add_x = r_acc;
        w_add_y = r_mag_b[0] ? r_mag_a : '0;
      end
      S_FIN: begin
        w_add_x = r_acc;
        w_add_y = RND;
      end
      default: ;
    endcase
  end

  assign w_sum = w_add_x + w_add_y + {{(AW-1){1'b0}}, w_add_cin};
  assign w_mag = w_sum[AW-1:FRAC];

  // Saturation of the EXEC sum and of the rounded, signed product
  always_comb begin
    w_exec_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    w_exec_res = w_sum[WIDTH-1:0];
    if (w_exec_ovf) w_exec_res = w_sum[WIDTH] ? SAT_NEG : SAT_POS;
    if (!r_sign) begin
      w_fin_ovf = (w_mag > MAG_POS);
      w_fin_res = w_fin_ovf ? SAT_POS : w_mag[WIDTH-1:0];
    end else begin
      w_fin_ovf = (w_mag > MAG_NEG);
      w_fin_res = w_fin_ovf ? SAT_NEG : (~w_mag[WIDTH-1:0] + ONE_W);
    end
  end

  // Operand capture, shift-add iteration and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_sign   <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= op_e'(bus.op);
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_mag_a <= {{(AW-WIDTH){1'b0}}, w_abs_a};
            r_mag_b <= w_abs_b;
            r_sign  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_EXEC: begin
          r_result <= w_exec_res;
          r_ovf    <= w_exec_ovf;
        end
        S_MUL: begin
          r_acc   <= w_sum;
          r_mag_a <= r_mag_a << 1;
          r_mag_b <= r_mag_b >> 1;
          r_cnt   <= r_cnt + CW'(1);
        end
        S_FIN: begin
          r_result <= w_fin_res;
          r_ovf    <= w_fin_ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.result    = r_result;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_fxp_alu_sequencer.sv
// tb/tb_fxp_alu_sequencer.sv - directed self-checking bench for fxp_alu_sequencer
module tb_fxp_alu_sequencer;

  localparam int WIDTH = 8;
  localparam int FRAC  = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   lat;

  fxp_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  fxp_alu_sequencer #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; returns at the falling edge after the accept edge
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    chk("in_ready_at_issue", int'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op       = 2'b00;
    bus.a        = 8'h5A;
    bus.b        = 8'hA5;
  endtask

  // Count falling edges until out_valid, bounded
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_res,
                        input logic exp_ovf, input int exp_lat);
    issue(op, a, b);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, int'(bus.result), int'(exp_res));
    chk({tag, "_ovf"}, int'(bus.ovf), int'(exp_ovf));
    chk({tag, "_busy"}, int'(bus.busy), 1);
    @(negedge clk);
    chk({tag, "_vld_drop"}, int'(bus.out_valid), 0);
    chk({tag, "_rdy_back"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = 2'b00;
    bus.a        = '0;
    bus.b        = '0;
    bus.out_ready = 1'b1;

    // Reset and idle state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_in_ready_after", int'(bus.in_ready), 1);

    // ADD/SUB/MOV with and without saturation
    run_op("add_sat", 2'b00, 8'h70, 8'h20, 8'h7F, 1'b1, 1);
    run_op("sub_sat", 2'b01, 8'h80, 8'h10, 8'h80, 1'b1, 1);
    run_op("add_ok",  2'b00, 8'h18, 8'h08, 8'h20, 1'b0, 1);
    run_op("sub_ok",  2'b01, 8'h10, 8'h30, 8'hE0, 1'b0, 1);
    run_op("mov",     2'b11, 8'h9C, 8'h11, 8'h9C, 1'b0, 1);

    // MUL basics, rounding and boundaries
    run_op("mul_2x3",   2'b10, 8'h20, 8'h30, 8'h60, 1'b0, 9);
    run_op("mul_neg",   2'b10, 8'h18, 8'hE0, 8'hD0, 1'b0, 9);
    run_op("mul_rnd_p", 2'b10, 8'h01, 8'h08, 8'h01, 1'b0, 9);
    run_op("mul_rnd_n", 2'b10, 8'hFF, 8'h08, 8'hFF, 1'b0, 9);
    run_op("mul_min",   2'b10, 8'h80, 8'h10, 8'h80, 1'b0, 9);
    run_op("mul_sat_p", 2'b10, 8'h80, 8'h80, 8'h7F, 1'b1, 9);
    run_op("mul_sat_n", 2'b10, 8'h40, 8'hC0, 8'h80, 1'b1, 9);
    run_op("mul_zero",  2'b10, 8'h00, 8'hC0, 8'h00, 1'b0, 9);

    // Backpressure with an ignored request during the stall
    bus.out_ready = 1'b0;
    issue(2'b10, 8'h20, 8'h30);
    wait_valid(lat);
    chk("bp_lat", lat, 9);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.in_valid = 1'b1;
        bus.op       = 2'b00;
        bus.a        = 8'h01;
        bus.b        = 8'h01;
      end else begin
        bus.in_valid = 1'b0;
      end
      chk("bp_result", int'(bus.result), 8'h60);
      chk("bp_valid", int'(bus.out_valid), 1);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("bp_hold_end", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", int'(bus.out_valid), 0);
    repeat (3) @(negedge clk);
    chk("bp_no_ghost_valid", int'(bus.out_valid), 0);
    chk("bp_no_ghost_busy", int'(bus.busy), 0);

    // Reset during MUL, with a request presented while in reset
    issue(2'b10, 8'h20, 8'h30);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.op       = 2'b00;
    bus.a        = 8'h22;
    bus.b        = 8'h22;
    @(negedge clk);
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_result", int'(bus.result), 0);
    chk("mid_rst_ovf", int'(bus.ovf), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(bus.busy), 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (bus.out_valid) seen++;
        @(negedge clk);
      end
      chk("aborted_no_valid", seen, 0);
    end
    run_op("add_after_rst", 2'b00, 8'h10, 8'h10, 8'h20, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
